// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply/divide unit.
//
// Accepts one operand pair per valid/ready handshake, runs BITS_PER_CYCLE
// shift-add (multiply) or restoring-division steps per clock and holds the
// result until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   in_valid   operands and op valid this cycle
//   in_ready   unit idle and able to accept a transaction
//   op         00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU
//   a, b       multiplicand/dividend, multiplier/divisor
//   out_valid  result valid
//   out_ready  consumer takes the result this cycle
//   result     selected result
//   zero       result == 0
//   overflow   MUL: high half nonzero; DIVU/REMU: divide-by-zero; MULHU: 0
module alu_muldiv_seq #(
  parameter int unsigned N              = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         overflow
);

  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpMulhu = 2'b01;
  localparam logic [1:0] OpDivu  = 2'b10;
  localparam logic [1:0] OpRemu  = 2'b11;

  localparam int unsigned   CntW    = $clog2(N + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(N);
  localparam logic [CntW-1:0] CntStep = CntW'(BITS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  // opa: multiplicand for multiply; dividend shifting out / quotient shifting in for divide.
  logic [N-1:0]      opa_q, opa_d;
  // opb: multiplier shifting right for multiply; constant divisor for divide.
  logic [N-1:0]      opb_q, opb_d;
  logic [2*N-1:0]    acc_q, acc_d;
  logic [N:0]        rem_q, rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]      result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;

  // Per-clock iteration temporaries.
  logic [2*N-1:0]    acc_c;
  logic [N-1:0]      opa_c;
  logic [N-1:0]      opb_c;
  logic [N:0]        rem_c;
  logic [N:0]        sum_c;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    acc_c    = acc_q;
    opa_c    = opa_q;
    opb_c    = opb_q;
    rem_c    = rem_q;
    sum_c    = '0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d  = op;
          opa_d = a;
          opb_d = b;
          acc_d = '0;
          rem_d = '0;
          cnt_d = '0;
          if (op[1] && (b == '0)) begin
            // Divide-by-zero bypasses the datapath entirely.
            result_d = (op == OpDivu) ? '1 : a;
            zero_d   = (result_d == '0);
            ovf_d    = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end

      StBusy: begin
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
          if (!op_q[1]) begin
            // Add into the high half, then shift the 2N-bit product right.
            sum_c = {1'b0, acc_c[2*N-1:N]} + (opb_c[0] ? {1'b0, opa_c} : '0);
            acc_c = {sum_c, acc_c[N-1:1]};
            opb_c = opb_c >> 1;
          end else begin
            rem_c = {rem_c[N-1:0], opa_c[N-1]};
            opa_c = {opa_c[N-2:0], 1'b0};
            if (rem_c >= {1'b0, opb_c}) begin
              rem_c    = rem_c - {1'b0, opb_c};
              opa_c[0] = 1'b1;
            end
          end
        end
        acc_d = acc_c;
        opa_d = opa_c;
        opb_d = opb_c;
        rem_d = rem_c;
        cnt_d = cnt_q + CntStep;

        if (cnt_d == CntLast) begin
          state_d = StDone;
          unique case (op_q)
            OpMul: begin
              result_d = acc_c[N-1:0];
              ovf_d    = |acc_c[2*N-1:N];
            end
            OpMulhu: begin
              result_d = acc_c[2*N-1:N];
              ovf_d    = 1'b0;
            end
            OpDivu: begin
              result_d = opa_c;
              ovf_d    = 1'b0;
            end
            OpRemu: begin
              result_d = rem_c[N-1:0];
              ovf_d    = 1'b0;
            end
            default: begin
              result_d = '0;
              ovf_d    = 1'b0;
            end
          endcase
          zero_d = (result_d == '0);
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: a 32-bit/1-bit-per-cycle instance and an
// 8-bit/2-bits-per-cycle instance, with a scoreboard queue per instance.
module tb_alu_muldiv_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, zero32, ovf32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, result32;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, ovf8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, result8;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t m32, m8;

  alu_muldiv_seq #(.N(32), .BITS_PER_CYCLE(1)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .op        (op32),
    .a         (a32),
    .b         (b32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .result    (result32),
    .zero      (zero32),
    .overflow  (ovf32)
  );

  alu_muldiv_seq #(.N(8), .BITS_PER_CYCLE(2)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .op        (op8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .result    (result8),
    .zero      (zero8),
    .overflow  (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned n, input logic [1:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
    logic [63:0] mask, p;
    exp_t        e;
    mask = (64'd1 << n) - 64'd1;
    p    = {32'b0, x} * {32'b0, y};
    e    = '0;
    case (o)
      2'b00: begin e.res = 32'(p & mask);         e.ovf = ((p >> n) != 0); end
      2'b01: begin e.res = 32'((p >> n) & mask);  e.ovf = 1'b0;            end
      2'b10: begin
        if (y == 0) begin e.res = 32'(mask); e.ovf = 1'b1; end
        else        begin e.res = x / y;     e.ovf = 1'b0; end
      end
      default: begin
        if (y == 0) begin e.res = x;     e.ovf = 1'b1; end
        else        begin e.res = x % y; e.ovf = 1'b0; end
      end
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  // Inputs change 1 time unit after the rising edge; everything is observed there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: compare when a result is actually handed over.
  always @(negedge clk) begin
    if (rst && out_valid32 && out_ready32) begin
      if (sb32.size() == 0) check("sb32_unexpected_result", 1, 0);
      else begin
        m32 = sb32.pop_front();
        check("res32", result32, m32.res);
        check("zero32", zero32, m32.zero);
        check("ovf32", ovf32, m32.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid8 && out_ready8) begin
      if (sb8.size() == 0) check("sb8_unexpected_result", 1, 0);
      else begin
        m8 = sb8.pop_front();
        check("res8", {24'b0, result8}, m8.res);
        check("zero8", zero8, m8.zero);
        check("ovf8", ovf8, m8.ovf);
      end
    end
  end

  // One transaction on either instance: accept, latency, optional backpressure, consume.
  task automatic tx(input bit w8, input logic [1:0] o, input logic [31:0] x,
                    input logic [31:0] y, input int unsigned hold, input bit pulse);
    exp_t        e;
    int unsigned lat, exp_lat, guard;
    e       = model(w8 ? 8 : 32, o, x, y);
    exp_lat = (o[1] && (y == 0)) ? 0 : (w8 ? 4 : 32);
    guard   = 0;
    while (!(w8 ? in_ready8 : in_ready32) && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check("in_ready_timeout", 0, 1);
    if (w8) begin
      in_valid8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
      sb8.push_back(e);
    end else begin
      in_valid32 = 1'b1; op32 = o; a32 = x; b32 = y;
      sb32.push_back(e);
    end
    step();
    // Scramble operands after the accept edge; the unit must have latched them.
    if (w8) begin
      in_valid8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    end else begin
      in_valid32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
    end
    check("busy_in_ready", w8 ? in_ready8 : in_ready32, 0);
    lat = 0;
    while (!(w8 ? out_valid8 : out_valid32) && lat < 100) begin
      step();
      lat++;
    end
    check("latency", lat, exp_lat);
    for (int unsigned h = 0; h < hold; h++) begin
      check("hold_valid", w8 ? out_valid8 : out_valid32, 1);
      check("hold_result", w8 ? {24'b0, result8} : result32, e.res);
      check("hold_in_ready", w8 ? in_ready8 : in_ready32, 0);
      if (w8) begin
        in_valid8 = pulse; a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        in_valid32 = pulse; a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
      end
      step();
    end
    if (w8) begin in_valid8 = 1'b0;  out_ready8 = 1'b1;  end
    else    begin in_valid32 = 1'b0; out_ready32 = 1'b1; end
    step();
    if (w8) out_ready8 = 1'b0;
    else    out_ready32 = 1'b0;
    check("post_out_valid", w8 ? out_valid8 : out_valid32, 0);
    check("post_in_ready", w8 ? in_ready8 : in_ready32, 1);
    check("post_result", w8 ? {24'b0, result8} : result32, e.res);
    check("post_ovf", w8 ? ovf8 : ovf32, e.ovf);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned spurious;
    logic [31:0] rx, ry;
    rst = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    in_valid8  = 1'b0; out_ready8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    #12;
    check("rst_in_ready", in_ready32, 1);
    check("rst_out_valid", out_valid32, 0);
    check("rst_result", result32, 0);
    check("rst_zero", zero32, 1);
    check("rst_ovf", ovf32, 0);
    check("rst_in_ready8", in_ready8, 1);
    step();
    rst = 1'b1;
    step();

    // Reset mid-BUSY aborts: nothing must ever come out for 7*9.
    in_valid32 = 1'b1; op32 = 2'b00; a32 = 32'd7; b32 = 32'd9;
    step();
    in_valid32 = 1'b0;
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid32, 0);
    check("abort_in_ready", in_ready32, 1);
    check("abort_result", result32, 0);
    step();
    rst = 1'b1;
    out_ready32 = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid32 || !in_ready32) spurious++;
    end
    check("abort_no_result", spurious, 0);
    out_ready32 = 1'b0;

    // Directed 32-bit cases.
    tx(1'b0, 2'b00, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    tx(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    tx(1'b0, 2'b10, 32'd100, 32'd7, 0, 1'b0);
    tx(1'b0, 2'b11, 32'd100, 32'd7, 0, 1'b0);
    tx(1'b0, 2'b10, 32'd3, 32'd5, 0, 1'b0);
    tx(1'b0, 2'b10, 32'h1234_5678, 32'd0, 0, 1'b0);
    tx(1'b0, 2'b11, 32'h1234_5678, 32'd0, 0, 1'b0);
    tx(1'b0, 2'b11, 32'd0, 32'd0, 1, 1'b0);
    // Backpressure with ignored in_valid pulses.
    tx(1'b0, 2'b10, 32'd100, 32'd7, 10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      rx = $urandom;
      ry = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      tx(1'b0, 2'($urandom), rx, ry, $urandom_range(0, 3), 1'b1);
    end

    // 8-bit, 2 bits per cycle.
    tx(1'b1, 2'b00, 32'h0F, 32'h11, 0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      rx = {24'b0, 8'($urandom)};
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : {24'b0, 8'($urandom)};
      tx(1'b1, 2'($urandom), rx, ry, $urandom_range(0, 2), 1'b1);
    end

    step();
    check("sb32_drained", sb32.size(), 0);
    check("sb8_drained", sb8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
